// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the GPR write-back path: register select, write request
// and round-robin pointer encoding.
package wb_pkg;

    localparam int unsigned NUM_REGS    = 32;
    localparam int unsigned L2_NUM_REGS = 5;
    localparam int unsigned WORD_SIZE   = 32;

    typedef logic [L2_NUM_REGS-1:0] reg_sel_t;
    typedef logic [WORD_SIZE-1:0]   word_t;

    typedef struct packed {
        reg_sel_t sel;
        word_t    data;
    } wb_req_t;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_ptr_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Producer handshakes, issue notification, GPR load port and pending scoreboard
// bundled between the producers/issue logic (master) and the arbiter (slave).
interface writeback_arbiter_if #(
    parameter int unsigned num_regs    = wb_pkg::NUM_REGS,
    parameter int unsigned l2_num_regs = wb_pkg::L2_NUM_REGS
);
    logic                          i_a_valid;
    logic                          o_a_ready;
    logic [l2_num_regs-1:0]        i_a_sel;
    logic [wb_pkg::WORD_SIZE-1:0]  i_a_data;
    logic                          i_b_valid;
    logic                          o_b_ready;
    logic [l2_num_regs-1:0]        i_b_sel;
    logic [wb_pkg::WORD_SIZE-1:0]  i_b_data;
    logic                          i_issue;
    logic [l2_num_regs-1:0]        i_issue_sel;
    logic                          o_load_gpr;
    logic [l2_num_regs-1:0]        o_load_gpr_sel;
    logic [wb_pkg::WORD_SIZE-1:0]  o_load_gpr_data;
    logic [num_regs-1:0]           o_pending;

    modport slave (
        input  i_a_valid, i_a_sel, i_a_data,
        input  i_b_valid, i_b_sel, i_b_data,
        input  i_issue, i_issue_sel,
        output o_a_ready, o_b_ready,
        output o_load_gpr, o_load_gpr_sel, o_load_gpr_data, o_pending
    );

    modport master (
        output i_a_valid, i_a_sel, i_a_data,
        output i_b_valid, i_b_sel, i_b_data,
        output i_issue, i_issue_sel,
        input  o_a_ready, o_b_ready,
        input  o_load_gpr, o_load_gpr_sel, o_load_gpr_data, o_pending
    );
endinterface

// File: rtl/writeback_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter: one-hot grant, pointer flips to the
// other requester after every grant and holds when idle.
module rr_arbiter2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    rr_ptr_t ptr;

    // Grant gated by reset so no ready can leak out while reset is asserted.
    always_comb begin
        grant = '0;
        if (rst_n) begin
            if (req[0] && (!req[1] || ptr == RR_A)) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= RR_A;
        end else if (grant[0]) begin
            ptr <= RR_B;
        end else if (grant[1]) begin
            ptr <= RR_A;
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: round-robin between ALU and LSU results into the single
// GPR write port, plus a pending-write scoreboard for RAW stall detection.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned num_regs    = NUM_REGS,
    parameter int unsigned l2_num_regs = L2_NUM_REGS
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    writeback_arbiter_if.slave  wb
);
    logic [1:0]             grant;
    logic                   granted;
    wb_req_t                gnt_req;
    logic [l2_num_regs-1:0] gnt_sel;
    logic [num_regs-1:0]    pend_nxt;

    rr_arbiter2 u_rr (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .req   ({wb.i_b_valid, wb.i_a_valid}),
        .grant (grant)
    );

    assign wb.o_a_ready = grant[0];
    assign wb.o_b_ready = grant[1];
    assign granted      = |grant;
    assign gnt_req      = grant[0] ? '{sel: wb.i_a_sel, data: wb.i_a_data}
                                   : '{sel: wb.i_b_sel, data: wb.i_b_data};
    assign gnt_sel      = gnt_req.sel;

    // Clear before set so an issue to the register being retired wins.
    always_comb begin
        pend_nxt = wb.o_pending;
        if (granted && gnt_sel != '0) begin
            pend_nxt[gnt_sel] = 1'b0;
        end
        if (wb.i_issue && wb.i_issue_sel != '0) begin
            pend_nxt[wb.i_issue_sel] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb.o_load_gpr      <= 1'b0;
            wb.o_load_gpr_sel  <= '0;
            wb.o_load_gpr_data <= '0;
            wb.o_pending       <= '0;
        end else begin
            wb.o_load_gpr <= granted && (gnt_sel != '0);
            if (granted) begin
                wb.o_load_gpr_sel  <= gnt_sel;
                wb.o_load_gpr_data <= gnt_req.data;
            end
            wb.o_pending <= pend_nxt;
        end
    end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Initiator/writer side of the GPR file's single synchronous write port.
- Accepts results from two producers through valid/ready handshakes: channel A (ALU) and channel B (load/store unit).
- Arbitrates between them round-robin and drives a registered load interface straight into the GPR file.
- Keeps a pending-write scoreboard so that issue logic can stall on RAW hazards.

Parameters:
- num_regs, `REG_FILE_SIZE, number of GPRs (scoreboard width).
- l2_num_regs, `L2_REG_FILE_SIZE, log2(num_regs) (select width).

Ports:
- i_clk  in  1  clock; all state updates on the positive edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_a_valid  in  1  channel A result valid.
- o_a_ready  out  1  channel A result accepted this cycle.
- i_a_sel  in  l2_num_regs  channel A destination register.
- i_a_data  in  `WORD_SIZE  channel A result.
- i_b_valid  in  1  channel B result valid.
- o_b_ready  out  1  channel B result accepted this cycle.
- i_b_sel  in  l2_num_regs  channel B destination register.
- i_b_data  in  `WORD_SIZE  channel B result.
- i_issue  in  1  an instruction with a destination register issues this cycle.
- i_issue_sel  in  l2_num_regs  destination of the issuing instruction.
- o_load_gpr  out  1  GPR write enable (to the GPR file).
- o_load_gpr_sel  out  l2_num_regs  GPR write select.
- o_load_gpr_data  out  `WORD_SIZE  GPR write data.
- o_pending  out  num_regs  bit n high means a write to rn is outstanding.

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - o_load_gpr, o_load_gpr_sel, o_load_gpr_data and o_pending all go to 0.
  - Round-robin pointer is set to favour A.
- Handshake:
  - A transfer occurs on a channel when valid and ready are both high at a clock edge.
  - o_a_ready and o_b_ready are combinational from the valids and the pointer, with no dependence on the data inputs.
  - At most one ready is high per cycle.
  - A ready is never high while i_rst_n is low.
- Arbitration:
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the channel favoured by the pointer.
  - After any grant, the pointer flips to favour the other channel.
  - Neither valid: no grant, pointer unchanged.
  - A producer holds valid/sel/data stable until its ready is seen. The block does not check this.
- Write stage:
  - A grant in cycle N drives o_load_gpr=1 with the granted sel/data in cycle N+1.
  - With no grant, o_load_gpr=0 and sel/data hold their previous values.
  - Fixed latency of 1 cycle; throughput of one write per cycle.
- r0 handling:
  - A transfer with sel=0 is accepted (ready high as normal) but produces o_load_gpr=0 in N+1.
  - The r0 transfer still counts as a grant for the pointer.
- Scoreboard:
  - i_issue with i_issue_sel≠0 sets o_pending[i_issue_sel] at the next edge.
  - A granted transfer with sel≠0 clears o_pending[sel] at the same edge as the grant, not in the write-stage cycle.
  - If issue and grant hit the same register in the same cycle, set wins: the new producer remains outstanding.
  - Issue and grant to different registers both take effect.
  - o_pending[0] is always 0.
  - A grant to a non-pending register is legal and leaves its bit at 0.
- Reset mid-operation:
  - An in-flight write-stage entry is discarded and o_load_gpr drops immediately.
  - The scoreboard clears.
  - Producers must re-present their results after reset.

Decomposition:
- Shared package (wb_pkg):
  - typedef reg_sel_t (logic [l2_num_regs-1:0]).
  - typedef wb_req_t: struct {sel, data}.
  - enum rr_ptr_t {RR_A, RR_B}.
- Sub-module rr_arbiter2:
  - 2-requester round-robin arbiter with a one-hot grant and the pointer flop.
  - Reused later for the load/store unit's memory-port arbitration.

Test Plan:
- Reset with A valid, sel=5, data=0xDEADBEEF held throughout; release reset -> o_a_ready=1 in the first cycle after release; next cycle o_load_gpr=1, sel=5, data=0xDEADBEEF; all outputs 0 during reset.
- A and B valid simultaneously for 4 cycles (A sel=3, B sel=4) -> grants alternate A,B,A,B; o_load_gpr stays high for 4 consecutive cycles with sel 3,4,3,4.
- Channel B transfer with sel=0, data=0x1234 -> o_b_ready=1; next cycle o_load_gpr=0; pointer now favours A.
- i_issue sel=7 at cycle 0 -> o_pending[7]=1 from cycle 1. A transfer sel=7 granted at cycle 3 -> o_pending[7]=0 from cycle 4. Issue sel=7 together with grant sel=7 -> o_pending[7] stays 1.
- i_issue sel=0 -> o_pending remains all-zero.
- Assert i_rst_n low mid-cycle while o_load_gpr=1 and o_pending=0x0000_0104 -> o_load_gpr and o_pending go to 0 without waiting for a clock edge.
